// File: rtl/sme_pattern_sched.sv
// rtl/sme_pattern_sched.sv - pattern ROM sequencer issuing one matcher job per terminator-delimited pattern
// Optional feature macro: SME_SKIP_EMPTY_EN (skip zero-length patterns without issuing a job).
module sme_pattern_sched #(
  parameter int          AW      = 7,
  parameter int          MAX_PAT = 16,
  parameter int          MAX_LEN = 32,
  parameter logic [7:0]  TERM    = 8'h0A,
  parameter logic [7:0]  EOL     = 8'h00
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] P_addr,
  input  logic [7:0]    P_data,
  output logic          job_valid,
  input  logic          job_ready,
  output logic [3:0]    job_pattern_no,
  output logic [AW-1:0] job_base,
  output logic [5:0]    job_len,
  output logic          job_trunc,
  input  logic          match_done,
  output logic          finish,
  output logic          pat_err
);

  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT_DONE, FINISH} state_t;

  state_t        state, next_state;
  logic [AW-1:0] ph_addr;      // address whose byte is on P_data this cycle
  logic          ph_valid;
  logic [AW-1:0] cur_base;
  logic [AW-1:0] resume;
  logic          resume_wrap;  // terminator sat at the last ROM address
  logic [5:0]    len;
  logic          trunc;
  logic [4:0]    cnt;

  logic is_eol, is_term, at_last, skip_empty, last_pat;

  assign is_eol   = (P_data == EOL);
  assign is_term  = (P_data == TERM);
  assign at_last  = (ph_addr == {AW{1'b1}});
  assign last_pat = (cnt == 5'(MAX_PAT - 1));

`ifdef SME_SKIP_EMPTY_EN
  assign skip_empty = (len == 6'd0);
`else
  assign skip_empty = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start) next_state = SCAN;
      SCAN: begin
        if (ph_valid) begin
          if (is_eol)                  next_state = FINISH;
          else if (is_term) begin
            if (!skip_empty)           next_state = ISSUE;
            else if (at_last)          next_state = FINISH;
          end
          else if (at_last)            next_state = FINISH;
        end
      end
      ISSUE:     if (job_ready) next_state = WAIT_DONE;
      WAIT_DONE: if (match_done) next_state = (last_pat || resume_wrap) ? FINISH : SCAN;
      FINISH:    if (start) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      P_addr         <= '0;
      ph_addr        <= '0;
      ph_valid       <= 1'b0;
      cur_base       <= '0;
      resume         <= '0;
      resume_wrap    <= 1'b0;
      len            <= '0;
      trunc          <= 1'b0;
      cnt            <= '0;
      job_valid      <= 1'b0;
      job_pattern_no <= '0;
      job_base       <= '0;
      job_len        <= '0;
      job_trunc      <= 1'b0;
      finish         <= 1'b0;
      pat_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            P_addr   <= '0;
            cur_base <= '0;
            len      <= '0;
            trunc    <= 1'b0;
            ph_valid <= 1'b0;
            cnt      <= '0;
            finish   <= 1'b0;
            pat_err  <= 1'b0;
          end
        end
        SCAN: begin
          P_addr   <= P_addr + 1'b1;
          ph_addr  <= P_addr;
          ph_valid <= 1'b1;
          if (ph_valid) begin
            if (is_eol) begin
              finish <= 1'b1;
            end else if (is_term) begin
              if (skip_empty) begin
                if (at_last) begin
                  pat_err <= 1'b1;
                  finish  <= 1'b1;
                end else begin
                  cur_base <= ph_addr + 1'b1;
                end
              end else begin
                job_valid      <= 1'b1;
                job_pattern_no <= cnt[3:0];
                job_base       <= cur_base;
                job_len        <= len;
                job_trunc      <= trunc;
                resume         <= ph_addr + 1'b1;
                resume_wrap    <= at_last;
              end
            end else if (at_last) begin
              pat_err <= 1'b1;
              finish  <= 1'b1;
            end else if (len == 6'(MAX_LEN)) begin
              trunc <= 1'b1;
            end else begin
              len <= len + 1'b1;
            end
          end
        end
        ISSUE: begin
          if (job_ready) job_valid <= 1'b0;
        end
        WAIT_DONE: begin
          if (match_done) begin
            cnt <= cnt + 1'b1;
            if (last_pat || resume_wrap) begin
              finish  <= 1'b1;
              pat_err <= resume_wrap && !last_pat;
            end else begin
              P_addr   <= resume;
              cur_base <= resume;
              len      <= '0;
              trunc    <= 1'b0;
              ph_valid <= 1'b0;
            end
          end
        end
        FINISH: begin
          if (start) finish <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_pattern_sched.sv
// tb/tb_sme_pattern_sched.sv - directed self-checking bench for sme_pattern_sched
module tb_sme_pattern_sched;

  logic       clk = 1'b0;
  logic       reset, start, job_ready, match_done;
  logic [6:0] P_addr;
  logic [7:0] P_data;
  logic       job_valid, job_trunc, finish, pat_err;
  logic [3:0] job_pattern_no;
  logic [6:0] job_base;
  logic [5:0] job_len;

  logic [7:0] rom [128];
  int npass = 0;
  int ntotal = 0;

  logic [3:0] g_no   [20];
  logic [6:0] g_base [20];
  logic [5:0] g_len  [20];
  logic       g_trunc[20];
  int         njobs;
  logic       timed_out;

  sme_pattern_sched dut (
    .clk(clk), .reset(reset), .start(start),
    .P_addr(P_addr), .P_data(P_data),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_pattern_no(job_pattern_no), .job_base(job_base),
    .job_len(job_len), .job_trunc(job_trunc),
    .match_done(match_done), .finish(finish), .pat_err(pat_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) P_data <= rom[P_addr];

  task automatic clear_rom(input logic [7:0] v);
    for (int i = 0; i < 128; i++) rom[i] = v;
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) rom[i] = s[i];
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; job_ready = 1'b0; match_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge of cycle 1 of the scan.
  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Matcher model: accepts every job, pulses done dly cycles after acceptance.
  task automatic run_jobs(input int dly);
    int cyc;
    cyc = 0;
    njobs = 0;
    job_ready = 1'b1;
    while (!finish && cyc < 3000) begin
      if (job_valid) begin
        if (njobs < 20) begin
          g_no[njobs] = job_pattern_no; g_base[njobs] = job_base;
          g_len[njobs] = job_len; g_trunc[njobs] = job_trunc;
        end
        njobs++;
        @(negedge clk);
        repeat (dly - 1) @(negedge clk);
        match_done = 1'b1;
        @(negedge clk);
        match_done = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    job_ready = 1'b0;
    timed_out = !finish;
  endtask

  task automatic test_reset();
    clear_rom(8'h00);
    do_reset();
    ntotal++;
    if ({P_addr, job_valid, job_pattern_no, job_base, job_len, job_trunc, finish, pat_err} !== 31'd0)
      $display("FAIL reset_outputs: got %h expected 0",
               {P_addr, job_valid, job_pattern_no, job_base, job_len, job_trunc, finish, pat_err});
    else npass++;
  endtask

  task automatic test_basic();
    clear_rom(8'h00);
    load_str("AB\nCDE\n");
    do_reset();
    start_pulse();
    for (int i = 0; i < 3; i++) begin
      ntotal++;
      if (P_addr !== 7'(i)) $display("FAIL basic_p_addr%0d: got %0d expected %0d", i, P_addr, i);
      else npass++;
      @(negedge clk);
    end
    ntotal++;
    if (job_valid !== 1'b0) $display("FAIL basic_valid_c4: got %b expected 0", job_valid);
    else npass++;
    @(negedge clk);
    ntotal++;
    if (job_valid !== 1'b1) $display("FAIL basic_valid_c5: got %b expected 1", job_valid);
    else npass++;
    run_jobs(3);
    ntotal++;
    if (timed_out || njobs != 2) $display("FAIL basic_njobs: got %0d (timeout %b) expected 2", njobs, timed_out);
    else npass++;
    ntotal++;
    if ({g_no[0], g_base[0], g_len[0], g_trunc[0]} !== {4'd0, 7'd0, 6'd2, 1'b0})
      $display("FAIL basic_job0: got no=%0d base=%0d len=%0d trunc=%b expected 0/0/2/0",
               g_no[0], g_base[0], g_len[0], g_trunc[0]);
    else npass++;
    ntotal++;
    if ({g_no[1], g_base[1], g_len[1], g_trunc[1]} !== {4'd1, 7'd3, 6'd3, 1'b0})
      $display("FAIL basic_job1: got no=%0d base=%0d len=%0d trunc=%b expected 1/3/3/0",
               g_no[1], g_base[1], g_len[1], g_trunc[1]);
    else npass++;
    ntotal++;
    if ({finish, pat_err} !== 2'b10) $display("FAIL basic_finish: got finish=%b pat_err=%b expected 1/0", finish, pat_err);
    else npass++;
  endtask

  task automatic test_empty();
`ifdef SME_SKIP_EMPTY_EN
    int exp_n = 1;
    int eb[3] = '{2, 0, 0};
    int el[3] = '{1, 0, 0};
`else
    int exp_n = 3;
    int eb[3] = '{0, 1, 2};
    int el[3] = '{0, 0, 1};
`endif
    clear_rom(8'h00);
    load_str("\n\nX\n");
    do_reset();
    start_pulse();
    run_jobs(2);
    ntotal++;
    if (timed_out || njobs != exp_n) $display("FAIL empty_njobs: got %0d expected %0d", njobs, exp_n);
    else npass++;
    for (int i = 0; i < exp_n && i < njobs; i++) begin
      ntotal++;
      if (g_no[i] !== 4'(i) || g_base[i] !== 7'(eb[i]) || g_len[i] !== 6'(el[i]))
        $display("FAIL empty_job%0d: got no=%0d base=%0d len=%0d expected %0d/%0d/%0d",
                 i, g_no[i], g_base[i], g_len[i], i, eb[i], el[i]);
      else npass++;
    end
  endtask

  task automatic test_trunc();
    clear_rom(8'h00);
    for (int i = 0; i < 40; i++) rom[i] = 8'h41;
    rom[40] = 8'h0A;
    do_reset();
    start_pulse();
    run_jobs(2);
    ntotal++;
    if (timed_out || njobs != 1 || g_len[0] !== 6'd32 || g_trunc[0] !== 1'b1 || g_base[0] !== 7'd0)
      $display("FAIL trunc_job: got n=%0d len=%0d trunc=%b base=%0d expected 1/32/1/0",
               njobs, g_len[0], g_trunc[0], g_base[0]);
    else npass++;
  endtask

  task automatic test_overrun();
    clear_rom(8'h41);
    do_reset();
    start_pulse();
    run_jobs(2);
    ntotal++;
    if (timed_out || njobs != 0 || pat_err !== 1'b1 || finish !== 1'b1)
      $display("FAIL overrun: got n=%0d pat_err=%b finish=%b expected 0/1/1", njobs, pat_err, finish);
    else npass++;
  endtask

  task automatic test_max_pat();
    clear_rom(8'h00);
    for (int i = 0; i < 17; i++) begin
      rom[2*i]   = 8'h41;
      rom[2*i+1] = 8'h0A;
    end
    do_reset();
    start_pulse();
    run_jobs(1);
    ntotal++;
    if (timed_out || njobs != 16) $display("FAIL maxpat_njobs: got %0d expected 16", njobs);
    else npass++;
    for (int i = 0; i < 16 && i < njobs; i++) begin
      ntotal++;
      if (g_no[i] !== 4'(i) || g_base[i] !== 7'(2*i) || g_len[i] !== 6'd1)
        $display("FAIL maxpat_job%0d: got no=%0d base=%0d len=%0d expected %0d/%0d/1",
                 i, g_no[i], g_base[i], g_len[i], i, 2*i);
      else npass++;
    end
  endtask

  task automatic test_stall_reset();
    logic [17:0] snap;
    logic        stable;
    int          cyc;
    clear_rom(8'h00);
    load_str("AB\nC\n");
    do_reset();
    start_pulse();
    cyc = 0;
    while (!job_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    ntotal++;
    if (!job_valid) $display("FAIL stall_wait: got job_valid=0 expected 1 within 20 cycles");
    else npass++;
    snap = {job_pattern_no, job_base, job_len, job_trunc};
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      match_done = (i == 4);
      @(negedge clk);
      if (!job_valid || {job_pattern_no, job_base, job_len, job_trunc} !== snap) stable = 1'b0;
    end
    match_done = 1'b0;
    ntotal++;
    if (!stable || snap !== {4'd0, 7'd0, 6'd2, 1'b0})
      $display("FAIL stall_stable: got stable=%b desc=%h expected 1/%h", stable, snap, {4'd0, 7'd0, 6'd2, 1'b0});
    else npass++;
    job_ready = 1'b1;
    @(negedge clk);
    job_ready = 1'b0;
    ntotal++;
    if (job_valid !== 1'b0) $display("FAIL stall_accept: got job_valid=%b expected 0", job_valid);
    else npass++;
    reset = 1'b1;
    @(negedge clk);
    ntotal++;
    if ({P_addr, job_valid, job_pattern_no, job_base, job_len, job_trunc, finish, pat_err} !== 31'd0)
      $display("FAIL midreset_outputs: got %h expected 0",
               {P_addr, job_valid, job_pattern_no, job_base, job_len, job_trunc, finish, pat_err});
    else npass++;
    reset = 1'b0;
    match_done = 1'b1;
    repeat (3) @(negedge clk);
    match_done = 1'b0;
    ntotal++;
    if ({P_addr, job_valid, finish} !== 9'd0)
      $display("FAIL midreset_idle: got %h expected 0", {P_addr, job_valid, finish});
    else npass++;
    start_pulse();
    ntotal++;
    if (P_addr !== 7'd0) $display("FAIL restart_addr0: got %0d expected 0", P_addr);
    else npass++;
    @(negedge clk);
    ntotal++;
    if (P_addr !== 7'd1) $display("FAIL restart_addr1: got %0d expected 1", P_addr);
    else npass++;
    run_jobs(2);
    ntotal++;
    if (timed_out || njobs != 2 || g_base[1] !== 7'd3 || g_len[1] !== 6'd1 || g_no[1] !== 4'd1)
      $display("FAIL restart_jobs: got n=%0d base1=%0d len1=%0d no1=%0d expected 2/3/1/1",
               njobs, g_base[1], g_len[1], g_no[1]);
    else npass++;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; job_ready = 1'b0; match_done = 1'b0;
    test_reset();
    test_basic();
    test_empty();
    test_trunc();
    test_overrun();
    test_max_pat();
    test_stall_reset();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/sme_pattern_sched.md
Name: sme_pattern_sched

Overview:
- Sequencer in front of the string-matching engine.
- Walks the 128x8 pattern ROM and splits it into terminator-delimited patterns.
- Hands each pattern to the matcher as a job (pattern_no, base address, length) and waits for the matcher's done pulse before issuing the next.
- Raises finish when the pattern list is exhausted.

Parameters:
- AW, 7, pattern ROM address width (128 entries).
- MAX_PAT, 16, maximum patterns issued; pattern_no is 4 bits.
- MAX_LEN, 32, longest legal pattern in bytes.
- TERM, 8'h0A, pattern terminator byte.
- EOL, 8'h00, end-of-list byte.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a scan from address 0
- P_addr  out  7  pattern ROM address (registered)
- P_data  in  8  pattern ROM data; the byte for address A is valid the cycle after P_addr==A
- job_valid  out  1  job descriptor valid
- job_ready  in  1  matcher accepts the job
- job_pattern_no  out  4  index of the issued pattern
- job_base  out  7  ROM address of the first pattern byte
- job_len  out  6  pattern length, saturated at MAX_LEN
- job_trunc  out  1  pattern longer than MAX_LEN
- match_done  in  1  one-cycle pulse; matcher finished the current job
- finish  out  1  all patterns processed
- pat_err  out  1  sticky: list ran off the end of the ROM without EOL

Behaviour:
- Reset: all outputs 0, state IDLE, pattern counter 0. Reset asserted mid-operation aborts immediately; any outstanding job is dropped.
- IDLE:
  - start=1 -> SCAN, P_addr=0 on the next cycle; clear finish, pat_err, counter.
  - start in any other state is ignored.
- SCAN:
  - P_addr increments by 1 every cycle.
  - Each returned byte is classified one cycle after its address. Ordinary byte: len+1, saturating at MAX_LEN, and set trunc on overflow.
  - TERM -> latch base/len/trunc, go ISSUE; record resume address = terminator address + 1.
  - EOL -> FINISH. Any partial pattern is discarded.
  - Address 127 returns a byte that is neither TERM nor EOL -> set pat_err, go FINISH, discard the partial pattern.
  - Prefetched bytes beyond the terminator are discarded.
  - Empty pattern (TERM with len=0): see Optional Feature.
- ISSUE:
  - job_valid=1 with descriptor stable until job_ready=1 is sampled.
  - On that edge: job_valid=0 -> WAIT_DONE.
- WAIT_DONE:
  - match_done=1 -> counter+1.
  - If counter reaches MAX_PAT -> FINISH. Otherwise -> SCAN from the resume address.
  - A match_done sampled in the same cycle the job is accepted, or in any state other than WAIT_DONE, is ignored.
- FINISH: finish=1, held until the next start or reset; then IDLE.
- Timing: "AB\n" at address 0, start sampled at edge 0:
  - P_addr=0,1,2 in cycles 1-3.
  - TERM seen in cycle 4.
  - job_valid=1 from cycle 5.
  - job_base=0, job_len=2.
- Resume: the first P_addr after match_done is the resume address, driven in the cycle following the done edge.

Optional Feature:
- Macro: SME_SKIP_EMPTY_EN.
- Defined: a TERM with len=0 issues no job and consumes no pattern number; scanning continues without leaving SCAN.
- Undefined: an empty pattern is issued as a normal job with job_len=0 and consumes a pattern number.

Test Plan:
- ROM "AB\nCDE\n\0", job_ready tied 1, match_done 3 cycles after accept -> jobs (0,base0,len2), (1,base3,len3); finish rises after the second done.
- ROM "\n\nX\n\0":
  - With SME_SKIP_EMPTY_EN: a single job (0,base2,len1).
  - Without it: jobs (0,0,0), (1,1,0), (2,2,1).
- A 40-byte pattern followed by TERM -> job_len=32, job_trunc=1, base=0.
- 127 non-terminator bytes plus a non-TERM/EOL byte at address 127 -> no job, pat_err=1, finish=1.
- 17 one-byte patterns -> exactly 16 jobs (pattern_no 0..15), then finish.
- Hold job_ready=0 for 10 cycles -> descriptor stable. Reset while in WAIT_DONE -> all outputs 0 next cycle; a later start restarts at P_addr=0.
